// File: rtl/processor.sv
// Single-cycle RV32 R-type ALU core. The program ROM, PC, decoder, 32x32 register
// file and ALU are all internal. The only visible output is the ALU zero flag.
module processor #(
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_DEPTH = 32
) (
  input  logic clock,
  input  logic reset,
  output logic zero
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_ctrl_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_t;

  // Builds one R-type instruction word.
  function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_RTYPE};
  endfunction

  // Fixed program. Everything past word 8 is addi x0,x0,0. That instruction is
  // not R-type, so it acts as a NOP here.
  function automatic logic [31:0] rom(input logic [AW-1:0] a);
    case (int'(a))
      0: return rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);  // add x3,x1,x2
      1: return rt(7'h20, 5'd3, 5'd3, 3'b000, 5'd4);  // sub x4,x3,x3
      2: return rt(7'h00, 5'd2, 5'd1, 3'b111, 5'd5);  // and x5,x1,x2
      3: return rt(7'h00, 5'd2, 5'd1, 3'b110, 5'd6);  // or  x6,x1,x2
      4: return rt(7'h00, 5'd3, 5'd1, 3'b100, 5'd7);  // xor x7,x1,x3
      5: return rt(7'h00, 5'd2, 5'd1, 3'b001, 5'd8);  // sll x8,x1,x2
      6: return rt(7'h00, 5'd1, 5'd8, 3'b101, 5'd9);  // srl x9,x8,x1
      7: return rt(7'h00, 5'd2, 5'd1, 3'b010, 5'd10); // slt x10,x1,x2
      8: return rt(7'h00, 5'd1, 5'd2, 3'b010, 5'd11); // slt x11,x2,x1
      default: return NOP;
    endcase
  endfunction

  logic [31:0]           pc;
  logic [DATA_WIDTH-1:0] regs [32];
  rtype_t                instr;
  alu_ctrl_t             alu_control;
  logic                  valid_rtype;
  logic [DATA_WIDTH-1:0] rd1, rd2, alu_result;
  logic                  slt_bit;

  assign instr = rtype_t'(rom(pc[AW+1:2]));

  // The read ports are asynchronous, and x0 always reads as zero.
  assign rd1 = (instr.rs1 == 5'd0) ? '0 : regs[instr.rs1];
  assign rd2 = (instr.rs2 == 5'd0) ? '0 : regs[instr.rs2];

  // Decode. Only funct7 values 0000000 and 0100000 are accepted, and 0100000
  // only together with SUB. Anything else decodes to a NOP.
  always_comb begin
    alu_control = ALU_ADD;
    valid_rtype = 1'b0;
    if (instr.opcode == OP_RTYPE && {instr.funct7[6], instr.funct7[4:0]} == 6'd0) begin
      valid_rtype = 1'b1;
      case ({instr.funct7[5], instr.funct3})
        4'b0_000: alu_control = ALU_ADD;
        4'b1_000: alu_control = ALU_SUB;
        4'b0_001: alu_control = ALU_SLL;
        4'b0_010: alu_control = ALU_SLT;
        4'b0_100: alu_control = ALU_XOR;
        4'b0_101: alu_control = ALU_SRL;
        4'b0_110: alu_control = ALU_OR;
        4'b0_111: alu_control = ALU_AND;
        default:  valid_rtype = 1'b0;
      endcase
    end
  end

  assign slt_bit = $signed(rd1) < $signed(rd2);

  // ALU. Invalid instructions force the result to 0.
  always_comb begin
    alu_result = '0;
    if (valid_rtype) begin
      case (alu_control)
        ALU_AND: alu_result = rd1 & rd2;
        ALU_OR:  alu_result = rd1 | rd2;
        ALU_ADD: alu_result = rd1 + rd2;
        ALU_XOR: alu_result = rd1 ^ rd2;
        ALU_SLL: alu_result = rd1 << rd2[4:0];
        ALU_SRL: alu_result = rd1 >> rd2[4:0];
        ALU_SUB: alu_result = rd1 - rd2;
        ALU_SLT: alu_result = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
        default: alu_result = '0;
      endcase
    end
  end

  assign zero = ~reset & valid_rtype & (alu_result == '0);

  // PC advance with wrap, and register-file write. Reset restores xi = i.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= DATA_WIDTH'(i);
    end else begin
      pc <= (pc + 32'd4) % 32'(IMEM_DEPTH * 4);
      if (valid_rtype && instr.rd != 5'd0) regs[instr.rd] <= alu_result;
    end
  end

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor. It compares the zero flag against a
// per-word expected table through a scoreboard queue, and checks the PC and
// registers against values derived from the program listing.
module tb_processor;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic zero;

  int checks = 0;
  int errors = 0;
  int zq[$];
  int zexp [32];
  int word;

  processor #(.DATA_WIDTH(32), .IMEM_DEPTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .zero (zero)
  );

  always #5 clock = ~clock;

  // Expected zero flag for each ROM word, taken from the program listing.
  initial begin
    for (int i = 0; i < 32; i++) zexp[i] = 0;
    zexp[1] = 1; zexp[2] = 1; zexp[8] = 1;
  end

  // Advance one rising edge. Afterwards time sits at the next falling edge,
  // plus a small settle delay.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  // Push the expected zero flag for the current word, then pop it and compare
  // it against the DUT.
  task automatic score_zero(input string tag);
    int e;
    zq.push_back(reset ? 0 : zexp[word]);
    e = zq.pop_front();
    checks++;
    if (zero !== e[0]) begin
      errors++;
      $display("FAIL %s word=%0d zero got=%b exp=%0d", tag, word, zero, e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    word = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      score_zero("reset_zero");
    end
    checks++;
    if (dut.pc !== 32'd0) begin errors++; $display("FAIL reset_pc got=%0d exp=0", dut.pc); end
    for (int r = 1; r <= 3; r++) begin
      checks++;
      if (dut.regs[r] !== 32'(r)) begin
        errors++; $display("FAIL reset_x%0d got=%0d exp=%0d", r, dut.regs[r], r);
      end
    end
  endtask

  task automatic test_program();
    int xexp [12];
    xexp[4] = 0; xexp[5] = 0; xexp[6] = 3; xexp[7] = 2;
    xexp[8] = 4; xexp[9] = 2; xexp[10] = 1; xexp[11] = 0;
    reset = 1'b0;
    #1;
    word = 0;
    score_zero("run_zero");
    for (int k = 1; k <= 9; k++) begin
      step();
      word = k;
      score_zero("run_zero");
      if (k == 1) begin
        checks++;
        if (dut.pc !== 32'd4) begin errors++; $display("FAIL first_pc got=%0d exp=4", dut.pc); end
        checks++;
        if (dut.regs[3] !== 32'd3) begin errors++; $display("FAIL first_x3 got=%0d exp=3", dut.regs[3]); end
      end
    end
    for (int r = 4; r <= 11; r++) begin
      checks++;
      if (dut.regs[r] !== 32'(xexp[r])) begin
        errors++; $display("FAIL prog_x%0d got=%0d exp=%0d", r, dut.regs[r], xexp[r]);
      end
    end
  endtask

  // Continue the run to 32 edges after release. The PC should wrap back to
  // word 0, and word 0 then executes again.
  task automatic test_wrap();
    for (int k = 10; k <= 32; k++) begin
      step();
      word = k % 32;
      score_zero("wrap_zero");
    end
    checks++;
    if (dut.pc !== 32'd0) begin errors++; $display("FAIL wrap_pc got=%0d exp=0", dut.pc); end
    step();
    word = 1;
    score_zero("wrap_zero");
    checks++;
    if (dut.regs[3] !== 32'd3) begin errors++; $display("FAIL wrap_x3 got=%0d exp=3", dut.regs[3]); end
    checks++;
    if (dut.pc !== 32'd4) begin errors++; $display("FAIL wrap_pc4 got=%0d exp=4", dut.pc); end
  endtask

  // Assert reset while word 5 (sll) is current. The program must restart and
  // x8 must go back to its initial value.
  task automatic test_reset_mid();
    reset = 1'b1; step(); reset = 1'b0; #1;
    for (int k = 1; k <= 5; k++) step();
    word = 5;
    checks++;
    if (dut.pc !== 32'd20) begin errors++; $display("FAIL mid_pc5 got=%0d exp=20", dut.pc); end
    reset = 1'b1; #1;
    score_zero("mid_zero");
    step();
    word = 0;
    score_zero("mid_zero");
    checks++;
    if (dut.pc !== 32'd0) begin errors++; $display("FAIL mid_pc got=%0d exp=0", dut.pc); end
    checks++;
    if (dut.regs[8] !== 32'd8) begin errors++; $display("FAIL mid_x8 got=%0d exp=8", dut.regs[8]); end
  endtask

  // Raise reset while word 1 is current, where zero would otherwise be 1. The
  // flag must drop immediately. After the edge, x4 must be back at its
  // initial value.
  task automatic test_back_to_back();
    reset = 1'b0; #1;
    step();
    word = 1;
    score_zero("b2b_zero");
    reset = 1'b1; #1;
    score_zero("b2b_forced");
    step();
    checks++;
    if (dut.regs[4] !== 32'd4) begin errors++; $display("FAIL b2b_x4 got=%0d exp=4", dut.regs[4]); end
    reset = 1'b0; #1;
    word = 0;
    score_zero("b2b_restart");
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_program();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
